// File: rtl/sha256_msg_padder.sv
// Fetches an N-word message from word-addressed memory, appends SHA-256 padding
// and hands it to the compression stage as 512-bit blocks over valid/ready.
module sha256_msg_padder #(
   parameter int NUM_OF_WORDS = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [15:0]  message_addr,
   output logic         mem_clk,
   output logic         mem_we,
   output logic [15:0]  mem_addr,
   input  logic [31:0]  mem_read_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] blk_data,
   output logic         blk_last,
   output logic [7:0]   blk_index,
   output logic         busy,
   output logic         done
);

   localparam int          NB       = (NUM_OF_WORDS + 2) / 16 + 1;
   localparam logic [15:0] N_W      = 16'(NUM_OF_WORDS);
   localparam logic [7:0]  LAST_BLK = 8'(NB - 1);
   localparam logic [15:0] LEN_LO_K = 16'(16 * NB - 1);
   localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);

   typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_t;

   state_t      state_reg, state_next;
   logic [15:0] base_reg, base_next;
   logic [15:0] mem_addr_reg, mem_addr_next;
   logic [7:0]  blk_reg, blk_next;
   logic [4:0]  cnt_reg, cnt_next;
   logic        done_reg, done_next;
   logic [7:0]  blk_inc;
   logic [15:0] cap_k;
   logic [31:0] pad_word;

   // Reads past the message are clamped to the last message word.
   function automatic logic [15:0] clip(input logic [15:0] k);
      return (k < N_W) ? k : N_W - 16'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         base_reg     <= '0;
         mem_addr_reg <= '0;
         blk_reg      <= '0;
         cnt_reg      <= '0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         base_reg     <= base_next;
         mem_addr_reg <= mem_addr_next;
         blk_reg      <= blk_next;
         cnt_reg      <= cnt_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      base_next     = base_reg;
      mem_addr_next = mem_addr_reg;
      blk_next      = blk_reg;
      cnt_next      = cnt_reg;
      done_next     = 1'b0;
      blk_inc       = blk_reg + 8'd1;
      // Slot being captured this cycle holds padded word 16*blk + c - 1.
      cap_k         = {4'b0, blk_reg, 4'b0} + 16'(cnt_reg) - 16'd1;
      if (cap_k < N_W)
         pad_word = mem_read_data;
      else if (cap_k == N_W)
         pad_word = 32'h8000_0000;
      else if (cap_k == LEN_LO_K)
         pad_word = LEN_BITS;
      else
         pad_word = 32'h0000_0000;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next    = FILL;
               base_next     = message_addr;
               mem_addr_next = message_addr;
               blk_next      = 8'd0;
               cnt_next      = 5'd0;
            end
         end
         FILL: begin
            cnt_next = cnt_reg + 5'd1;
            if (cnt_reg < 5'd15)
               mem_addr_next = base_reg + clip({4'b0, blk_reg, 4'b0} + 16'(cnt_reg) + 16'd1);
            if (cnt_reg == 5'd16) begin
               state_next = PRESENT;
               cnt_next   = 5'd0;
            end
         end
         PRESENT: begin
            if (blk_ready) begin
               if (blk_reg == LAST_BLK) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next    = FILL;
                  blk_next      = blk_inc;
                  cnt_next      = 5'd0;
                  mem_addr_next = base_reg + clip({4'b0, blk_inc, 4'b0});
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   for (genvar gi = 0; gi < 16; gi++) begin : g_slot
      logic [31:0] slot_reg;
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            slot_reg <= '0;
         else if (state_reg == FILL && cnt_reg == 5'(gi + 1))
            slot_reg <= pad_word;
      end
      assign blk_data[32*gi +: 32] = slot_reg;
   end

   assign mem_clk   = clk;
   assign mem_we    = 1'b0;
   assign mem_addr  = mem_addr_reg;
   assign blk_valid = (state_reg == PRESENT);
   assign blk_last  = (state_reg == PRESENT) && (blk_reg == LAST_BLK);
   assign blk_index = blk_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench: three padder instances (N = 20, 13, 14) sharing one memory model.
module tb_sha256_msg_padder;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_v [3];
   logic         ready_v [3];
   logic [15:0]  addr_v  [3];
   logic         mclk_v  [3];
   logic         we_v    [3];
   logic [15:0]  maddr_v [3];
   logic [31:0]  rd_v    [3];
   logic         valid_v [3];
   logic [511:0] data_v  [3];
   logic         last_v  [3];
   logic [7:0]   idx_v   [3];
   logic         busy_v  [3];
   logic         done_v  [3];

   logic [31:0]  mem [65536];
   int           done_cnt [3];
   logic [15:0]  max14;
   int           n_checks = 0;
   int           n_fail = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int NW = (gi == 0) ? 20 : ((gi == 1) ? 13 : 14);
      sha256_msg_padder #(.NUM_OF_WORDS(NW)) u_dut (
         .clk(clk), .reset(reset), .start(start_v[gi]), .message_addr(addr_v[gi]),
         .mem_clk(mclk_v[gi]), .mem_we(we_v[gi]), .mem_addr(maddr_v[gi]),
         .mem_read_data(rd_v[gi]), .blk_valid(valid_v[gi]), .blk_ready(ready_v[gi]),
         .blk_data(data_v[gi]), .blk_last(last_v[gi]), .blk_index(idx_v[gi]),
         .busy(busy_v[gi]), .done(done_v[gi]));
   end

   // One-cycle read latency memory per instance
   always @(posedge clk)
      for (int i = 0; i < 3; i++) rd_v[i] <= mem[maddr_v[i]];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) if (done_v[i]) done_cnt[i]++;
      if (busy_v[2] && maddr_v[2] > max14) max14 = maddr_v[2];
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] msg_words(input logic [31:0] first, input int count);
      logic [511:0] b = '0;
      for (int w = 0; w < count; w++) b[32*w +: 32] = first + 32'(w);
      return b;
   endfunction

   task automatic wait_valid(input int d, output int cyc);
      cyc = 1;
      while (!valid_v[d] && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // mode 0: ready held high; 1: 10-cycle stall on block 0; 2: start pulse while presenting
   task automatic run(input int d, input logic [15:0] addr, input int mode, input int nb,
                      input logic [511:0] e0, input logic [511:0] e1, input string name);
      int           cyc;
      logic [511:0] snap_d;
      logic [15:0]  snap_a;
      logic         stable;
      done_cnt[d] = 0;
      ready_v[d]  = (mode == 0);
      addr_v[d]   = addr;
      start_v[d]  = 1'b1;
      @(negedge clk);
      start_v[d]  = 1'b0;
      check($sformatf("%s_busy", name), busy_v[d], 1);
      for (int b = 0; b < nb; b++) begin
         wait_valid(d, cyc);
         check($sformatf("%s_lat%0d", name, b), cyc, 18);
         check($sformatf("%s_data%0d", name, b), data_v[d], (b == 0) ? e0 : e1);
         check($sformatf("%s_idx%0d", name, b), idx_v[d], b);
         check($sformatf("%s_last%0d", name, b), last_v[d], (b == nb - 1));
         if (mode == 1 && b == 0) begin
            snap_d = data_v[d];
            snap_a = maddr_v[d];
            stable = 1'b1;
            repeat (10) begin
               @(negedge clk);
               if (!valid_v[d] || data_v[d] !== snap_d || maddr_v[d] !== snap_a) stable = 1'b0;
            end
            check($sformatf("%s_stall", name), stable, 1);
         end
         if (mode == 2 && b == 0) begin
            start_v[d] = 1'b1;
            addr_v[d]  = 16'h0200;
            @(negedge clk);
            start_v[d] = 1'b0;
            check($sformatf("%s_poke_valid", name), valid_v[d], 1);
         end
         ready_v[d] = 1'b1;
         @(negedge clk);
         $display("blk %s idx=%0d last=%0d word0=%08h", name, b, (b == nb - 1), ((b == 0) ? e0[31:0] : e1[31:0]));
      end
      check($sformatf("%s_done_hi", name), {busy_v[d], done_v[d]}, 2'b01);
      @(negedge clk);
      check($sformatf("%s_done_lo", name), done_v[d], 0);
      repeat (20) @(negedge clk);
      check($sformatf("%s_done_cnt", name), done_cnt[d], 1);
      check($sformatf("%s_idle", name), busy_v[d], 0);
      addr_v[d] = 16'h0000;
   endtask

   task automatic check_zero(input string tag, input int d);
      check({tag, "_ctl"}, {valid_v[d], last_v[d], idx_v[d], busy_v[d], done_v[d], maddr_v[d], we_v[d]}, 0);
      check({tag, "_data"}, data_v[d], 0);
   endtask

   initial begin
      logic [511:0] e20_0, e20_1, e13, e14_0, e14_1;
      int           cyc;
      for (int a = 0; a < 65536; a++) mem[a] = 32'hDEAD_0000 | 32'(a);
      for (int i = 0; i < 20; i++) mem[16'h0040 + i] = 32'(i + 1);
      for (int i = 0; i < 14; i++) mem[16'h0100 + i] = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < 20; i++) mem[16'h0200 + i] = 32'hBB00_0000 + 32'(i);
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0; ready_v[i] = 1'b0; addr_v[i] = 16'h0; done_cnt[i] = 0;
      end
      max14 = 16'h0;

      e20_0 = msg_words(32'd1, 16);
      e20_1 = msg_words(32'd17, 4);
      e20_1[32*4 +: 32]  = 32'h8000_0000;
      e20_1[32*15 +: 32] = 32'h0000_0280;
      e13 = msg_words(32'hA000_0000, 13);
      e13[32*13 +: 32] = 32'h8000_0000;
      e13[32*15 +: 32] = 32'h0000_01A0;
      e14_0 = msg_words(32'hA000_0000, 14);
      e14_0[32*14 +: 32] = 32'h8000_0000;
      e14_1 = '0;
      e14_1[32*15 +: 32] = 32'h0000_01C0;

      repeat (3) @(negedge clk);
      check_zero("reset", 0);
      reset = 1'b0;
      @(negedge clk);

      run(0, 16'h0040, 0, 2, e20_0, e20_1, "n20");
      run(1, 16'h0100, 0, 1, e13, '0, "n13");
      max14 = 16'h0;
      run(2, 16'h0100, 0, 2, e14_0, e14_1, "n14");
      check("n14_max_addr", max14, 16'h010D);
      run(0, 16'h0040, 1, 2, e20_0, e20_1, "stall");

      // Reset at fill cycle 7 of block 1
      ready_v[0] = 1'b1;
      addr_v[0]  = 16'h0040;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_valid(0, cyc);
      check("rst_pre_lat", cyc, 18);
      @(negedge clk);
      repeat (7) @(negedge clk);
      check("rst_pre_busy", {busy_v[0], idx_v[0]}, {1'b1, 8'd1});
      reset = 1'b1;
      #1;
      check_zero("rst_mid", 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run(0, 16'h0040, 0, 2, e20_0, e20_1, "rerun");

      run(0, 16'h0040, 2, 2, e20_0, e20_1, "poke");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
